// File: rtl/hex_scan_ctrl_pkg.sv
// Shared types and widths for the HEX display scan sequencer.
package hex_scan_pkg;
    localparam int SEL_W  = 2;
    localparam int BYTE_W = 8;
    localparam int CTR_W  = 16;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        HOLD  = 2'd1,
        OV_HI = 2'd2,
        OV_LO = 2'd3
    } state_e;

    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] sel);
        return sel + 1'b1;
    endfunction
endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Source, control and display signals shared between the sequencer and its environment.
interface hex_scan_ctrl_if;
    import hex_scan_pkg::*;

    logic [BYTE_W-1:0] in0, in1, in2, in3;
    logic              mode_auto;
    logic              advance;
    logic              hold;
    logic [CTR_W-1:0]  ctr_in;
    logic              ctr_req;
    logic [SEL_W-1:0]  select;
    logic [BYTE_W-1:0] disp_byte;
    logic              overlay_active;

    modport master (
        output in0, in1, in2, in3, mode_auto, advance, hold, ctr_in, ctr_req,
        input  select, disp_byte, overlay_active
    );

    modport slave (
        input  in0, in1, in2, in3, mode_auto, advance, hold, ctr_in, ctr_req,
        output select, disp_byte, overlay_active
    );
endinterface

// File: rtl/hex_scan_ctrl_prescaler.sv
// Free-running divider: pulses o_tick for one cycle each time the count wraps at PRESCALE-1.
module hex_scan_prescaler #(
    parameter int PRESCALE = 50_000_000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_clear,
    output logic o_tick
);
    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);

    logic [TW-1:0] r_tick_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (i_clear) begin
            r_tick_cnt <= '0;
        end else if (i_en) begin
            r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    assign o_tick = i_en & ~i_clear & (r_tick_cnt == TICK_LAST);
endmodule

// File: rtl/hex_scan_ctrl.sv
// Rotates four debug bytes onto the HEX display, with freeze and a timed counter overlay.
// The overlay (OV_HI/OV_LO, counter snapshot) exists only when HEX_SCAN_OVERLAY_EN is defined.
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int PRESCALE       = 50_000_000,
    parameter int OVERLAY_CYCLES = 100_000_000
) (
    input  logic           clock,
    input  logic           reset_n,
    hex_scan_ctrl_if.slave bus
);
    state_e            r_state, w_state_next;
    logic [SEL_W-1:0]  r_select, w_select_next;
    logic [BYTE_W-1:0] r_disp, w_disp_next;
    logic [BYTE_W-1:0] w_in_sel;
    logic              r_adv_q, r_mode_q;
    logic              w_adv_edge, w_tick, w_tick_clear;

    always_comb begin
        case (r_select)
            2'd0:    w_in_sel = bus.in0;
            2'd1:    w_in_sel = bus.in1;
            2'd2:    w_in_sel = bus.in2;
            default: w_in_sel = bus.in3;
        endcase
    end

    assign w_adv_edge = bus.advance & ~r_adv_q;
    // Counter idles at 0 outside SCAN and in manual mode, so every return to SCAN starts a fresh period.
    assign w_tick_clear = (r_state != SCAN) | ~bus.mode_auto | (bus.mode_auto ^ r_mode_q);

    hex_scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clock   (clock),
        .reset_n (reset_n),
        .i_en    (bus.mode_auto),
        .i_clear (w_tick_clear),
        .o_tick  (w_tick)
    );

`ifdef HEX_SCAN_OVERLAY_EN
    localparam int OV_W = $clog2(OVERLAY_CYCLES);
    localparam logic [OV_W-1:0] OV_HALF_LAST = OV_W'(OVERLAY_CYCLES / 2 - 1);
    localparam logic [OV_W-1:0] OV_LAST      = OV_W'(OVERLAY_CYCLES - 1);

    logic             r_ov_active, w_ov_active_next;
    logic [CTR_W-1:0] r_ctr_snap, w_ctr_snap_next;
    logic [OV_W-1:0]  r_ov_cnt, w_ov_cnt_next;
`else
    logic w_unused_ovl;
    assign w_unused_ovl = ^{bus.ctr_in, bus.ctr_req, 1'(OVERLAY_CYCLES % 2)};
`endif

    always_comb begin
        w_state_next  = r_state;
        w_select_next = r_select;
        w_disp_next   = r_disp;
`ifdef HEX_SCAN_OVERLAY_EN
        w_ov_active_next = r_ov_active;
        w_ctr_snap_next  = r_ctr_snap;
        w_ov_cnt_next    = r_ov_cnt;
`endif
        case (r_state)
            SCAN: begin
                w_disp_next = w_in_sel;
                if (bus.hold) begin
                    w_state_next = HOLD;
                end else if (w_tick | (~bus.mode_auto & w_adv_edge)) begin
                    w_select_next = sel_inc(r_select);
                end
            end
            HOLD: begin
                if (!bus.hold) begin
                    w_state_next = SCAN;
                end
            end
`ifdef HEX_SCAN_OVERLAY_EN
            OV_HI: begin
                w_ov_cnt_next = r_ov_cnt + 1'b1;
                if (r_ov_cnt == OV_HALF_LAST) begin
                    w_state_next = OV_LO;
                    w_disp_next  = r_ctr_snap[BYTE_W-1:0];
                end
            end
            OV_LO: begin
                if (r_ov_cnt == OV_LAST) begin
                    w_ov_active_next = 1'b0;
                    w_ov_cnt_next    = '0;
                    w_disp_next      = w_in_sel;
                    w_state_next     = bus.hold ? HOLD : SCAN;
                end else begin
                    w_ov_cnt_next = r_ov_cnt + 1'b1;
                end
            end
`endif
            default: w_state_next = SCAN;
        endcase
`ifdef HEX_SCAN_OVERLAY_EN
        // A request overrides everything decided above, including a same-cycle advance.
        if (bus.ctr_req) begin
            w_state_next     = OV_HI;
            w_select_next    = r_select;
            w_ctr_snap_next  = bus.ctr_in;
            w_ov_cnt_next    = '0;
            w_disp_next      = bus.ctr_in[CTR_W-1:BYTE_W];
            w_ov_active_next = 1'b1;
        end
`endif
    end

    // Mode history resets to auto so the first auto rotation lands on the PRESCALE-th edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= SCAN;
            r_select <= '0;
            r_disp   <= '0;
            r_adv_q  <= 1'b0;
            r_mode_q <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_select <= w_select_next;
            r_disp   <= w_disp_next;
            r_adv_q  <= bus.advance;
            r_mode_q <= bus.mode_auto;
        end
    end

`ifdef HEX_SCAN_OVERLAY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ov_active <= 1'b0;
            r_ctr_snap  <= '0;
            r_ov_cnt    <= '0;
        end else begin
            r_ov_active <= w_ov_active_next;
            r_ctr_snap  <= w_ctr_snap_next;
            r_ov_cnt    <= w_ov_cnt_next;
        end
    end

    assign bus.overlay_active = r_ov_active;
`else
    assign bus.overlay_active = 1'b0;
`endif

    assign bus.select    = r_select;
    assign bus.disp_byte = r_disp;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed vector bench for hex_scan_ctrl with PRESCALE=4, OVERLAY_CYCLES=6.
module tb_hex_scan_ctrl;
    logic clock;
    logic reset_n;
    int   checks;
    int   errors;

    hex_scan_ctrl_if hif();

    hex_scan_ctrl #(
        .PRESCALE       (4),
        .OVERLAY_CYCLES (6)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (hif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         n;
        logic       mode;
        logic       adv;
        logic       hold;
        logic [1:0] sel;
        logic [7:0] disp;
    } vec_t;

    vec_t vt[$];

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task chk_out(input string nm, input logic [1:0] sel, input logic [7:0] disp, input logic ov);
        chk({nm, "_sel"}, 16'(hif.select), 16'(sel));
        chk({nm, "_disp"}, 16'(hif.disp_byte), 16'(disp));
        chk({nm, "_ov"}, 16'(hif.overlay_active), 16'(ov));
    endtask

    initial begin
        logic [7:0] exp_a[6];
        logic [7:0] exp_b[6];
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        hif.in0 = 8'h11; hif.in1 = 8'h22; hif.in2 = 8'h33; hif.in3 = 8'h44;
        hif.mode_auto = 1'b1; hif.advance = 1'b0; hif.hold = 1'b0;
        hif.ctr_in = 16'h0000; hif.ctr_req = 1'b0;

        // auto rotation: sel = floor(k/4), disp = in[floor((k-1)/4)] after edge k
        vt.push_back(vec_t'{1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h11});
        vt.push_back(vec_t'{2, 1'b1, 1'b0, 1'b0, 2'd0, 8'h11});
        vt.push_back(vec_t'{1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h11});
        vt.push_back(vec_t'{1, 1'b1, 1'b0, 1'b0, 2'd1, 8'h22});
        vt.push_back(vec_t'{4, 1'b1, 1'b0, 1'b0, 2'd2, 8'h33});
        vt.push_back(vec_t'{4, 1'b1, 1'b0, 1'b0, 2'd3, 8'h44});
        vt.push_back(vec_t'{3, 1'b1, 1'b0, 1'b0, 2'd0, 8'h44});
        vt.push_back(vec_t'{1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h11});
        // manual: three pulses, the third held high for 10 cycles
        vt.push_back(vec_t'{1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h11});
        vt.push_back(vec_t'{1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h11});
        vt.push_back(vec_t'{1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h22});
        vt.push_back(vec_t'{1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h22});
        vt.push_back(vec_t'{1, 1'b0, 1'b0, 1'b0, 2'd2, 8'h33});
        vt.push_back(vec_t'{1, 1'b0, 1'b1, 1'b0, 2'd3, 8'h33});
        vt.push_back(vec_t'{9, 1'b0, 1'b1, 1'b0, 2'd3, 8'h44});
        vt.push_back(vec_t'{1, 1'b0, 1'b0, 1'b0, 2'd3, 8'h44});
        // step round to select 2
        vt.push_back(vec_t'{1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h44});
        vt.push_back(vec_t'{1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h11});
        vt.push_back(vec_t'{1, 1'b0, 1'b1, 1'b0, 2'd1, 8'h11});
        vt.push_back(vec_t'{1, 1'b0, 1'b0, 1'b0, 2'd1, 8'h22});
        vt.push_back(vec_t'{1, 1'b0, 1'b1, 1'b0, 2'd2, 8'h22});
        vt.push_back(vec_t'{1, 1'b0, 1'b0, 1'b0, 2'd2, 8'h33});

        cyc(2);
        chk_out("reset", 2'd0, 8'h00, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            hif.mode_auto = vt[i].mode;
            hif.advance   = vt[i].adv;
            hif.hold      = vt[i].hold;
            cyc(vt[i].n);
            chk_out($sformatf("vec%0d", i), vt[i].sel, vt[i].disp, 1'b0);
            $display("vec %0d: sel=%0d disp=%h ov=%b", i, hif.select, hif.disp_byte, hif.overlay_active);
        end

        // hold snapshot survives source change and advance edges
        hif.hold = 1'b1;
        cyc(1);
        chk_out("hold_enter", 2'd2, 8'h33, 1'b0);
        hif.in2 = 8'hAA;
        cyc(1);
        chk("hold_frozen_disp", 16'(hif.disp_byte), 16'h0033);
        hif.advance = 1'b1;
        cyc(1);
        chk_out("hold_adv", 2'd2, 8'h33, 1'b0);
        hif.advance = 1'b0;
        cyc(1);
        chk("hold_adv_dropped", 16'(hif.select), 16'd2);
        hif.hold = 1'b0;
        cyc(2);
        chk_out("hold_release", 2'd2, 8'hAA, 1'b0);
        hif.in2 = 8'h33;
        cyc(1);
        chk("scan_resume_disp", 16'(hif.disp_byte), 16'h0033);
        $display("hold: sel=%0d disp=%h", hif.select, hif.disp_byte);

        // mode change clears the prescaler; terminal tick coincides with hold rising
        hif.mode_auto = 1'b1;
        cyc(4);
        chk("tick_pre", 16'(hif.select), 16'd2);
        hif.hold = 1'b1;
        cyc(1);
        chk("hold_beats_tick", 16'(hif.select), 16'd2);
        cyc(1);
        chk("hold_beats_tick2", 16'(hif.select), 16'd2);
        hif.hold = 1'b0;
        hif.mode_auto = 1'b0;
        cyc(2);
        chk_out("tick_hold_exit", 2'd2, 8'h33, 1'b0);
        $display("tick/hold: sel=%0d disp=%h", hif.select, hif.disp_byte);

`ifdef HEX_SCAN_OVERLAY_EN
        exp_a = '{8'hBE, 8'hBE, 8'hBE, 8'hEF, 8'hEF, 8'hEF};
        exp_b = '{8'h12, 8'h12, 8'h12, 8'h34, 8'h34, 8'h34};
        hif.ctr_in = 16'hBEEF; hif.ctr_req = 1'b1;
        cyc(1);
        hif.ctr_req = 1'b0; hif.ctr_in = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(1);
            chk_out($sformatf("ov%0d", i), 2'd2, exp_a[i], 1'b1);
        end
        cyc(1);
        chk_out("ov_exit", 2'd2, 8'h33, 1'b0);
        $display("overlay: sel=%0d disp=%h ov=%b", hif.select, hif.disp_byte, hif.overlay_active);

        hif.ctr_in = 16'hBEEF; hif.ctr_req = 1'b1;
        cyc(1);
        hif.ctr_req = 1'b0;
        cyc(3);
        chk("ov2_lo_before", 16'(hif.disp_byte), 16'h00EF);
        hif.ctr_in = 16'h1234; hif.ctr_req = 1'b1;
        cyc(1);
        hif.ctr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc(1);
            chk_out($sformatf("ovr%0d", i), 2'd2, exp_b[i], 1'b1);
        end
        cyc(1);
        chk_out("ovr_exit", 2'd2, 8'h33, 1'b0);
        $display("re-request: sel=%0d disp=%h", hif.select, hif.disp_byte);

        hif.ctr_in = 16'h5A5A; hif.ctr_req = 1'b1; hif.advance = 1'b1;
        cyc(1);
        hif.ctr_req = 1'b0;
        chk_out("req_adv", 2'd2, 8'h5A, 1'b1);
        cyc(6);
        chk_out("req_adv_exit", 2'd2, 8'h33, 1'b0);
        hif.advance = 1'b0;
        cyc(1);
        $display("req+adv: sel=%0d disp=%h", hif.select, hif.disp_byte);

        hif.ctr_in = 16'hBEEF; hif.ctr_req = 1'b1;
        cyc(1);
        hif.ctr_req = 1'b0;
        cyc(3);
        chk("rst_pre_lo", 16'(hif.disp_byte), 16'h00EF);
`else
        exp_a = '{8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        exp_b = exp_a;
        hif.ctr_in = 16'hBEEF; hif.ctr_req = 1'b1; hif.advance = 1'b1;
        cyc(1);
        hif.ctr_req = 1'b0; hif.advance = 1'b0;
        chk_out("req_ignored", 2'd3, 8'h33, 1'b0);
        cyc(1);
        chk_out("req_ignored2", 2'd3, 8'h44, 1'b0);
        $display("req ignored: sel=%0d disp=%h", hif.select, hif.disp_byte);
`endif
        #2 reset_n = 1'b0;
        #1;
        chk_out("async_rst", 2'd0, 8'h00, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1);
        chk_out("post_rst", 2'd0, 8'h11, 1'b0);
        $display("reset: sel=%0d disp=%h ov=%b", hif.select, hif.disp_byte, hif.overlay_active);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Sequencer that shares the single two-digit HEX display between four 8-bit processor debug sources (in0..in3) and a 16-bit event counter. It rotates the source select on a prescaled timer or on manual key presses, and can freeze the current value. A counter-overlay request briefly pre-empts the rotation. Its registered `select` and `disp_byte` drive the existing 7-segment decode path.

## Interface
- `PRESCALE`, 50_000_000: clock cycles per auto-rotate step; must be ≥ 2.
- `OVERLAY_CYCLES`, 100_000_000: total overlay duration; must be even and ≥ 2. The high byte shows for the first half, the low byte for the second.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in0`, `in1`, `in2`, `in3` in 8 each: display sources.
- `mode_auto` in 1: 1 = timer rotation, 0 = manual rotation.
- `advance` in 1: synchronised key level, active-high. Only a rising edge acts.
- `hold` in 1: level. While high, freezes a snapshot of the displayed byte.
- `ctr_in` in 16: counter value. Sampled only on `ctr_req`.
- `ctr_req` in 1: single-cycle overlay request.
- `select` out 2: current source index.
- `disp_byte` out 8: byte to decode.
- `overlay_active` out 1: high while the counter is shown.

## Operation
- **States:**
  - `SCAN`
  - `HOLD`
  - `OV_HI`
  - `OV_LO`
- **Priority each cycle:** `ctr_req` > `hold` > advance/tick.
- **SCAN:**
  - `disp_byte` <= in[`select`], one-cycle registered latency.
  - Auto mode: `tick_cnt` counts 0..PRESCALE-1. At PRESCALE-1 it wraps to 0 and `select` <= `select`+1 mod 4 (3→0).
  - Manual mode: `tick_cnt` is held at 0. A rising edge of `advance` increments `select` mod 4.
  - Any change of `mode_auto` clears `tick_cnt`.
- **SCAN→HOLD:** when `hold`=1.
  - The snapshot is the in[`select`] value sampled that cycle.
  - `disp_byte` stays constant thereafter, even if the sources change.
  - `select` does not change.
- **HOLD→SCAN:** when `hold`=0. `tick_cnt` clears and `select` is kept.
- **Any state→OV_HI:** on `ctr_req`.
  - Snapshot `ctr_in` into `ctr_snap`.
  - Set `ov_cnt` to 0.
  - Drive `disp_byte` <= `ctr_snap[15:8]`.
  - Set `overlay_active` to 1.
- **OV_HI→OV_LO:** when `ov_cnt` = OVERLAY_CYCLES/2-1. `disp_byte` <= `ctr_snap[7:0]`.
- **OV_LO exit:** when `ov_cnt` = OVERLAY_CYCLES-1.
  - Go to HOLD if `hold`=1. The snapshot is re-taken from in[`select`].
  - Otherwise go to SCAN.
  - `tick_cnt` clears.
  - `overlay_active` falls.
- **Boundary rules:**
  - `ctr_req` during an overlay re-snapshots `ctr_in` and restarts at OV_HI with `ov_cnt` = 0.
  - An `advance` edge in HOLD, OV_HI or OV_LO is dropped, not queued.
  - `ctr_req` and an `advance` edge in the same cycle: the overlay wins and the advance is dropped.
  - Tick terminal count in the same cycle as `hold` rising: `hold` wins and `select` is unchanged.
  - An auto tick in the same cycle as an `advance` edge in manual mode cannot happen, because `tick_cnt` is idle in manual mode.
- **Edge detect:** a one-flop `adv_q` register; rising edge = `advance` & ~`adv_q`. `adv_q` updates in every state.

## Timing
- **Reset values** (asynchronous, immediate on `reset_n`=0):
  - state SCAN
  - `select` 0
  - `disp_byte` 8'h00
  - `overlay_active` 0
  - `tick_cnt`, `ov_cnt`, `ctr_snap`, `adv_q` all 0
- **Reset mid-overlay:** aborts to SCAN with `select` 0.
- **First rotation after reset release (auto mode):** `select`=1 on the PRESCALE-th rising edge.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.
- **Request / advance latency:** `ctr_req` or an `advance` edge at edge N is visible on the outputs after edge N.
- **Overlay timing:**
  - `overlay_active` is high for exactly OVERLAY_CYCLES cycles.
  - The high byte shows for exactly OVERLAY_CYCLES/2 cycles.
- **Counter widths:** `tick_cnt` and `ov_cnt` are `$clog2` of their parameter.

## Configuration
- **`HEX_SCAN_OVERLAY_EN` defined:** overlay states, `ctr_snap` and `ov_cnt` are present, behaving as above.
- **`HEX_SCAN_OVERLAY_EN` undefined:**
  - `ctr_in` and `ctr_req` ports remain but are ignored.
  - `overlay_active` is tied to 0.
  - OV_HI and OV_LO are unreachable and removed.
  - `ctr_req` has no effect in any state.

## Structure
- **Shared package `hex_scan_pkg`:**
  - state enum (SCAN, HOLD, OV_HI, OV_LO)
  - `SEL_W`=2
  - `BYTE_W`=8
  - `CTR_W`=16
- **Sub-module `hex_scan_prescaler`:**
  - Inputs: enable and clear.
  - Output: a one-cycle tick at terminal count.
  - Parameter: PRESCALE.

## Test plan
Bench parameters: PRESCALE=4, OVERLAY_CYCLES=6, sources in0..in3 = 8'h11/8'h22/8'h33/8'h44.
- **Auto rotation:** reset then `mode_auto`=1 → `select` steps 0,1,2,3,0 every 4 cycles; `disp_byte` follows 11,22,33,44,11.
- **Manual advance:** `mode_auto`=0, three advance pulses, then `advance` held high for 10 cycles → `select`=3, with exactly one increment per rising edge.
- **Hold snapshot:** `hold`=1 at `select`=2, then in2 changed to 8'hAA → `disp_byte` stays 8'h33 and advance edges are ignored; releasing `hold` → `disp_byte`=8'hAA.
- **Overlay:** `ctr_req` with `ctr_in`=16'hBEEF → `disp_byte` is 8'hBE for 3 cycles, then 8'hEF for 3 cycles; `overlay_active` is high for 6 cycles; then SCAN resumes at the same `select`.
- **Overlay collisions:**
  - A second `ctr_req` (16'h1234) at overlay cycle 4 → 8'h12 for 3 cycles, then 8'h34.
  - `ctr_req` in the same cycle as an advance edge → `select` is unchanged.
- **Reset mid-overlay:** `reset_n` pulse during OV_LO → all outputs are 0 immediately and `select`=0.
